// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if
//   Groups the driver-FIFO side and the packet-bus side of the round-robin arbiter.
//   Optional macro: ARB_STATS_EN adds the pkt_cnt / drop_cnt statistics signals.
// Signals
//   pndng     driver i has a packet at its FIFO head
//   D_pop     head packet of driver i at bits [i*pckg_sz +: pckg_sz]
//   pop       one-hot pop strobe to the granted driver FIFO
//   push      push strobe(s) to the destination driver(s)
//   D_push    packet on the bus, meaningful while any push bit is high
//   grant_id  index of the driver currently or last granted
//   busy      arbiter is moving a packet
//   pkt_cnt   routed packets (ARB_STATS_EN only)
//   drop_cnt  dropped packets (ARB_STATS_EN only)
// Modports
//   master  the arbiter
//   slave   the driver FIFOs and bus terminals
interface bus_rr_arbiter_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic [3:0]               grant_id;
  logic                     busy;
`ifdef ARB_STATS_EN
  logic [15:0]              pkt_cnt;
  logic [15:0]              drop_cnt;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, grant_id, busy, pkt_cnt, drop_cnt
  );
  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, grant_id, busy, pkt_cnt, drop_cnt
  );
`else
  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, grant_id, busy
  );
  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, grant_id, busy
  );
`endif
endinterface

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Round-robin controller for the shared packet bus. One pending driver is granted,
//   its head packet is popped and latched, then pushed to the destination named in
//   the header byte, or to every driver except the source for the broadcast ID.
//   Each packet takes three cycles: IDLE (arbitrate) -> POP -> PUSH.
//   Optional macro: ARB_STATS_EN adds pkt_cnt / drop_cnt counters on the interface.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    bus_rr_arbiter_if.master: pndng, D_pop in; pop, push, D_push, grant_id,
//          busy (and pkt_cnt, drop_cnt with ARB_STATS_EN) out
module bus_rr_arbiter #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         rr_ptr;
  logic [3:0]         grant_id;
  logic [3:0]         winner;
  logic [3:0]         ptr_nxt;
  logic [pckg_sz-1:0] pkt_reg;
  logic [pckg_sz-1:0] head_pkt;
  logic [drvrs-1:0]   dest_vec;
  logic [drvrs-1:0]   pop_vec;
  logic [drvrs-1:0]   push_vec;
  logic               busy;

  // First requester at or after ptr, wrapping modulo drvrs.
  function automatic logic [3:0] rr_pick(input logic [drvrs-1:0] req,
                                         input logic [3:0]       ptr);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < drvrs; k++) begin
      idx = (int'(ptr) + k) % drvrs;
      if (!found && req[idx]) begin
        pick  = 4'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Destination strobes for a packet from src; all-zero means the packet is dropped.
  function automatic logic [drvrs-1:0] route(input logic [pckg_sz-1:0] pkt,
                                             input logic [3:0]         src);
    logic [7:0] id;
    id = pkt[pckg_sz-1 -: 8];
    if (id == broadcast)
      return ~(ONE << src);
    else if ((int'(id) < drvrs) && (id != {4'b0000, src}))
      return ONE << id;
    else
      return '0;
  endfunction

  assign winner   = rr_pick(bus.pndng, rr_ptr);
  assign head_pkt = bus.D_pop[int'(grant_id)*pckg_sz +: pckg_sz];
  assign dest_vec = route(pkt_reg, grant_id);
  assign ptr_nxt  = 4'((int'(grant_id) + 1) % drvrs);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: fixed three-cycle walk, no back-to-back bypass
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.pndng) state_nxt = POP;
      POP:     state_nxt = PUSH;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: pop and push live in different states, so never overlap
  always_comb begin
    pop_vec  = '0;
    push_vec = '0;
    busy     = 1'b0;
    case (state)
      POP: begin
        pop_vec = ONE << grant_id;
        busy    = 1'b1;
      end
      PUSH: begin
        push_vec = dest_vec;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant, packet latch and pointer. pkt_reg doubles as D_push so the bus value
  // holds between packets; pop is issued even if pndng dropped meanwhile.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      pkt_reg  <= '0;
    end else begin
      case (state)
        IDLE:    if (|bus.pndng) grant_id <= winner;
        POP:     pkt_reg <= head_pkt;
        PUSH:    rr_ptr <= ptr_nxt;
        default: ;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  // A broadcast counts as one routed packet; both counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (state == PUSH) begin
      if (|dest_vec) pkt_cnt  <= pkt_cnt + 16'd1;
      else           drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.pkt_cnt  = pkt_cnt;
  assign bus.drop_cnt = drop_cnt;
`endif

  assign bus.pop      = pop_vec;
  assign bus.push     = push_vec;
  assign bus.D_push   = pkt_reg;
  assign bus.grant_id = grant_id;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter
//   Bench for bus_rr_arbiter (drvrs=4, pckg_sz=16). Driver FIFOs are modelled as
//   queues. A transaction-level reference walks free -> popping -> pushing and, for
//   every upcoming cycle, queues the outputs the arbiter must show; a separate
//   monitor pops and compares one entry per cycle. ARB_STATS_EN also checks counters.
module tb_bus_rr_arbiter;
  localparam int         D  = 4;
  localparam int         W  = 16;
  localparam logic [7:0] BC = 8'hFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.drvrs(D), .pckg_sz(W)) bus ();

  bus_rr_arbiter #(.drvrs(D), .pckg_sz(W), .broadcast(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [D-1:0] pop;
    logic [D-1:0] push;
    logic [W-1:0] dpush;
    logic [3:0]   gid;
    logic         busy;
    logic [15:0]  pkts;
    logic [15:0]  drops;
  } rec_t;

  typedef logic [W-1:0] pq_t[$];

  rec_t exp_q[$];
  pq_t  fq[D];

  int         checks = 0;
  int         errors = 0;
  int         ph     = 0;   // 0 free, 1 popping, 2 pushing
  int         m_ptr  = 0;
  int         m_gid  = 0;
  int         m_pkts = 0;
  int         m_drops = 0;
  logic [W-1:0] m_dpush = '0;
  bit         pop_pend = 0;
  int         pop_idx  = 0;
  bit         rand_en  = 0;
  bit         rst_req  = 1;

  // Pending driver closest to ptr going upward (mod D).
  function automatic int pick(input logic [D-1:0] p, input int ptr);
    int best = -1;
    int bd   = D;
    for (int i = 0; i < D; i++) begin
      if (p[i] && (((i - ptr + D) % D) < bd)) begin
        bd   = (i - ptr + D) % D;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [D-1:0] dest(input logic [W-1:0] p, input int src);
    int           id;
    logic [D-1:0] v;
    id = int'(p[W-1 -: 8]);
    v  = '0;
    if (id == int'(BC)) begin
      for (int i = 0; i < D; i++) if (i != src) v[i] = 1'b1;
    end else if (id < D && id != src) begin
      v[id] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] gen_pkt(input int src);
    int         sel;
    logic [7:0] id;
    sel = int'($urandom_range(0, 9));
    if (sel <= 4)      id = 8'($urandom_range(0, D-1));
    else if (sel <= 6) id = BC;
    else if (sel <= 8) id = 8'($urandom_range(D, 254));
    else               id = 8'(src);
    return {id, 8'($urandom)};
  endfunction

  // One clock of stimulus plus the expected outputs after the coming edge.
  task automatic step();
    rec_t         r;
    logic [D-1:0] pend;
    logic [D*W-1:0] lanes;
    logic [W-1:0] junk;
    @(negedge clk);
    if (pop_pend) begin
      if (fq[pop_idx].size() > 0) junk = fq[pop_idx].pop_front();
      pop_pend = 0;
    end
    if (rand_en)
      for (int i = 0; i < D; i++)
        if (fq[i].size() < 4 && $urandom_range(0, 3) == 0) fq[i].push_back(gen_pkt(i));
    pend  = '0;
    lanes = '0;
    for (int i = 0; i < D; i++)
      if (fq[i].size() > 0) begin
        pend[i]          = 1'b1;
        lanes[i*W +: W]  = fq[i][0];
      end
    bus.pndng = pend;
    bus.D_pop = lanes;
    reset     = rst_req;
    r.pop  = '0;
    r.push = '0;
    r.busy = 1'b0;
    if (rst_req) begin
      if (ph == 1) begin
        pop_pend = 1;
        pop_idx  = m_gid;
      end
      ph = 0; m_ptr = 0; m_gid = 0; m_dpush = '0; m_pkts = 0; m_drops = 0;
    end else if (ph == 0) begin
      if (pend != '0) begin
        m_gid  = pick(pend, m_ptr);
        r.pop  = D'(1) << m_gid;
        r.busy = 1'b1;
        ph     = 1;
      end
    end else if (ph == 1) begin
      m_dpush  = lanes[m_gid*W +: W];
      r.push   = dest(m_dpush, m_gid);
      r.busy   = 1'b1;
      pop_pend = 1;
      pop_idx  = m_gid;
      ph       = 2;
    end else begin
      if (dest(m_dpush, m_gid) != '0) m_pkts = (m_pkts + 1) % 65536;
      else                            m_drops = (m_drops + 1) % 65536;
      m_ptr = (m_gid + 1) % D;
      ph    = 0;
    end
    r.dpush = m_dpush;
    r.gid   = 4'(m_gid);
    r.pkts  = 16'(m_pkts);
    r.drops = 16'(m_drops);
    exp_q.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pop",      32'(bus.pop),      32'(e.pop));
        chk("push",     32'(bus.push),     32'(e.push));
        chk("busy",     32'(bus.busy),     32'(e.busy));
        chk("grant_id", 32'(bus.grant_id), 32'(e.gid));
        chk("D_push",   32'(bus.D_push),   32'(e.dpush));
`ifdef ARB_STATS_EN
        chk("pkt_cnt",  32'(bus.pkt_cnt),  32'(e.pkts));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(e.drops));
`endif
      end
    end
  end

  initial begin
    bus.pndng = '0;
    bus.D_pop = '0;
    repeat (3) step();
    rst_req = 0;
    repeat (2) step();

    // Single packet from driver 0 to driver 2
    fq[0].push_back(16'h02AB);
    repeat (6) step();

    // Fresh pointer, all drivers held pending, each addressed to its neighbour
    rst_req = 1; step(); rst_req = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < D; i++) fq[i].push_back({8'((i + 1) % D), 8'(16 * i + k)});
    repeat (42) step();

    // Broadcast from driver 2, then bad-id and self-addressed drops from driver 1
    fq[2].push_back(16'hFF55);
    repeat (6) step();
    fq[1].push_back(16'h0711);
    fq[1].push_back(16'h0111);
    repeat (9) step();

    // Quiet bus
    repeat (20) step();

    // Reset while the arbiter is in POP
    fq[3].push_back(16'h0155);
    step();
    rst_req = 1; step(); rst_req = 0;
    repeat (6) step();

    // Randomized traffic with occasional mid-POP resets
    rand_en = 1;
    for (int c = 0; c < 3000; c++) begin
      rst_req = (ph == 1) && ($urandom_range(0, 199) == 0);
      step();
    end
    rst_req = 0;
    rand_en = 0;
    repeat (80) step();

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
